// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, default widths and helpers for the data-memory
// arbiter that sits between the MEM stage, an external port and datamemory.
package dmem_arb_pkg;

  localparam int unsigned DMEM_AW_DEF    = 16;
  localparam int unsigned DMEM_DW_DEF    = 16;
  localparam int unsigned STARVE_MAX_DEF = 8;

  // PIPE is the normal pipeline-priority state; FORCE lasts one cycle and
  // hands the memory to the external port.
  typedef enum logic {
    PIPE  = 1'b0,
    FORCE = 1'b1
  } arb_state_t;

  // Width needed to hold a count from 0 up to and including maxCount.
  function automatic int unsigned starveCntWidth(input int unsigned maxCount);
    return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of consecutive cycles in which the
// external port asked for the memory and was refused. Clear wins over inc.
// at_max_o looks at the value the counter is about to take, so the arbiter
// can switch to FORCE on the same edge where the count reaches MAX.
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEF,
  parameter int unsigned W   = starveCntWidth(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, otherwise increment until saturated.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MaxVal)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max_o = (count_d == MaxVal);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage and
// one external requester (loader / debug). The pipeline has priority.
// Build option DMEM_ARB_STARVE_EN: when defined, a starvation counter forces
// one external access (stalling the pipeline) after STARVE_MAX refusals;
// when undefined, the external port only gets cycles the pipeline leaves idle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW         = DMEM_AW_DEF,
  parameter int unsigned DW         = DMEM_DW_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_rd,
  input  logic          pipe_wr,
  input  logic [AW-1:0] pipe_addr,
  input  logic [DW-1:0] pipe_wdata,
  output logic [DW-1:0] pipe_rdata,
  output logic          pipe_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata
);

  // A zero threshold has no meaning for the forced-grant scheme.
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be at least 1");
  end

  logic          pipe_act;
  logic          ext_rd_gnt;
  logic          ext_rvalid_q;
  logic          ext_rvalid_d;
  logic [DW-1:0] ext_rdata_q;
  logic [DW-1:0] ext_rdata_d;

  assign pipe_act = pipe_rd | pipe_wr;

`ifdef DMEM_ARB_STARVE_EN
  arb_state_t state_q;
  logic       force_gnt;
  logic       cnt_inc;
  logic       cnt_clr;
  logic       cnt_at_max;

  // In FORCE the external port wins only if it is still asking; if it
  // dropped its request the pipeline is served normally and not stalled.
  assign force_gnt  = (state_q == FORCE) && ext_req && !rst;
  assign ext_gnt    = !rst && ext_req && ((state_q == FORCE) || !pipe_act);
  assign pipe_stall = force_gnt && pipe_act;

  assign cnt_inc = (state_q == PIPE) && ext_req && pipe_act;
  assign cnt_clr = ext_gnt || !ext_req;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (cnt_inc),
    .clr_i    (cnt_clr),
    .at_max_o (cnt_at_max)
  );

  // Arbitration FSM: enter FORCE on the edge the refusal count hits max,
  // and always leave it after exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PIPE;
    end else begin
      case (state_q)
        PIPE:    if (cnt_at_max) state_q <= FORCE;
        FORCE:   state_q <= PIPE;
        default: state_q <= PIPE;
      endcase
    end
  end
`else
  assign ext_gnt    = !rst && ext_req && !pipe_act;
  assign pipe_stall = 1'b0;
`endif

  // Memory port steering: external when granted, otherwise the pipeline,
  // whose strobes are suppressed while it is stalled or in reset.
  assign mem_addr   = ext_gnt ? ext_addr  : pipe_addr;
  assign mem_wdata  = ext_gnt ? ext_wdata : pipe_wdata;
  assign mem_wr     = !rst && (ext_gnt ? ext_we  : (pipe_wr && !pipe_stall));
  assign mem_rd     = !rst && (ext_gnt ? !ext_we : (pipe_rd && !pipe_stall));
  assign pipe_rdata = mem_rdata;

  assign ext_rd_gnt = ext_gnt && !ext_we;

  // Capture read data on a granted external read; hold it otherwise.
  always_comb begin
    ext_rvalid_d = ext_rd_gnt;
    ext_rdata_d  = ext_rd_gnt ? mem_rdata : ext_rdata_q;
  end

  // External read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  // A read granted just before reset must not report valid data while
  // reset is being applied.
  assign ext_rvalid = ext_rvalid_q && !rst;
  assign ext_rdata  = ext_rdata_q;

  // MEM stage must never request a read and a write together.
  assert property (@(posedge clk) disable iff (rst) !(pipe_rd && pipe_wr));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// datamemory, a shadow copy of memory contents, and a queue of expected
// external read data. Follows DMEM_ARB_STARVE_EN the same way as the design.
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_rd, pipe_wr;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata, pipe_rdata;
  logic          pipe_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_wr, mem_rd;

  logic [DW-1:0] mem    [0:65535];
  logic [DW-1:0] shadow [0:65535];
  logic          preloadWe;
  logic [AW-1:0] preloadAddr;
  logic [DW-1:0] preloadData;

  logic [DW-1:0] expQ [$];
  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    string         name;
    logic          prd, pwr;
    logic [15:0]   paddr, pwdata;
    logic          ereq, ewe;
    logic [15:0]   eaddr, ewdata;
    logic          gnt, stall, mrd, mwr;
    logic [15:0]   maddr, mwdata;
    logic          chkPrdata;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .STARVE_MAX (SM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_rd    (pipe_rd),
    .pipe_wr    (pipe_wr),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_rdata (pipe_rdata),
    .pipe_stall (pipe_stall),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata)
  );

  // Behavioural datamemory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (preloadWe) mem[preloadAddr] <= preloadData;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic prd, input logic pwr,
                               input logic [15:0] pa, input logic [15:0] pd,
                               input logic er, input logic ew,
                               input logic [15:0] ea, input logic [15:0] ed);
    pipe_rd = prd; pipe_wr = pwr; pipe_addr = pa; pipe_wdata = pd;
    ext_req = er;  ext_we  = ew;  ext_addr  = ea; ext_wdata  = ed;
  endtask

  task automatic driveIdle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Read an address through the pipeline port and compare with the shadow.
  task automatic readBack(input logic [15:0] addr);
    applyStimulus(1'b1, 1'b0, addr, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput($sformatf("readBack[%04h]", addr), pipe_rdata, shadow[addr]);
    nextCycle();
  endtask

  // Pipeline writes every cycle while the external port asks to write.
  task automatic starveRun(input string tag, input int cycles, input int grantAt,
                           input logic [15:0] ea, input logic [15:0] ed,
                           input logic [15:0] pdBase);
    logic [15:0] pd;
    for (int k = 1; k <= cycles; k++) begin
      pd = 16'(pdBase + k);
      applyStimulus(1'b0, 1'b1, 16'h0060, pd, 1'b1, 1'b1, ea, ed);
      @(negedge clk);
      checkOutput($sformatf("%s.gnt[%0d]", tag, k), ext_gnt, k == grantAt);
      checkOutput($sformatf("%s.stall[%0d]", tag, k), pipe_stall, k == grantAt);
      if (k == grantAt) begin
        checkOutput($sformatf("%s.memWr[%0d]", tag, k), mem_wr, 1'b1);
        checkOutput($sformatf("%s.memAddr[%0d]", tag, k), mem_addr, ea);
        shadow[ea] = ed;
      end else begin
        shadow[16'h0060] = pd;
      end
      nextCycle();
    end
  endtask

  // Every external read-data pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (ext_rvalid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("rvalidUnexpected", ext_rvalid, 1'b0);
      end else begin
        checkOutput("extRdata", ext_rdata, expQ.pop_front());
      end
    end
  end

  initial begin
    logic pr, pw;

    vecs[0] = '{"extRdIdle", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000,
                1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0};
    vecs[1] = '{"pipePriority", 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h1111,
                1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1};
    vecs[2] = '{"pipeWrite", 1'b0, 1'b1, 16'h0006, 16'h3333, 1'b0, 1'b0, 16'h0000, 16'h0000,
                1'b0, 1'b0, 1'b0, 1'b1, 16'h0006, 16'h3333, 1'b0};
    vecs[3] = '{"extWrIdle", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0030, 16'hA5A5,
                1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, 16'hA5A5, 1'b0};
    vecs[4] = '{"idleFollow", 1'b0, 1'b0, 16'h0099, 16'h4444, 1'b0, 1'b1, 16'h0077, 16'h9999,
                1'b0, 1'b0, 1'b0, 1'b0, 16'h0099, 16'h4444, 1'b0};
    vecs[5] = '{"pipeRdWritten", 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                1'b0, 1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1};
    vecs[6] = '{"pipeRdUntouched", 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1};
    vecs[7] = '{"extRdBack", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000,
                1'b1, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0};
    vecs[8] = '{"pipeRdPreload", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1};
    vecs[9] = '{"extDeniedByWrite", 1'b0, 1'b1, 16'h0007, 16'h2222, 1'b1, 1'b0, 16'h0044, 16'h0000,
                1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 16'h2222, 1'b0};

    // Reset with random legal inputs while preloading memory.
    rst = 1'b1;
    driveIdle();
    preloadWe = 1'b1; preloadAddr = 16'h0010; preloadData = 16'hBEEF;
    shadow[16'h0010] = 16'hBEEF;
    nextCycle();
    for (int c = 0; c < 2; c++) begin
      pr = 1'($urandom_range(0, 1));
      pw = !pr && 1'($urandom_range(0, 1));
      applyStimulus(pr, pw, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      preloadAddr = (c == 0) ? 16'h0005 : 16'h0040;
      preloadData = (c == 0) ? 16'h5A5A : 16'h7777;
      shadow[preloadAddr] = preloadData;
      @(negedge clk);
      checkOutput($sformatf("reset.rvalid[%0d]", c), ext_rvalid, 1'b0);
      checkOutput($sformatf("reset.rdata[%0d]", c), ext_rdata, 16'h0000);
      checkOutput($sformatf("reset.memWr[%0d]", c), mem_wr, 1'b0);
      checkOutput($sformatf("reset.memRd[%0d]", c), mem_rd, 1'b0);
      checkOutput($sformatf("reset.stall[%0d]", c), pipe_stall, 1'b0);
      checkOutput($sformatf("reset.gnt[%0d]", c), ext_gnt, 1'b0);
      nextCycle();
    end
    rst = 1'b0;
    preloadWe = 1'b0;
    driveIdle();
    nextCycle();

    // Single-cycle vectors, each followed by an idle cycle.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].prd, vecs[i].pwr, vecs[i].paddr, vecs[i].pwdata,
                    vecs[i].ereq, vecs[i].ewe, vecs[i].eaddr, vecs[i].ewdata);
      @(negedge clk);
      checkOutput({vecs[i].name, ".gnt"}, ext_gnt, vecs[i].gnt);
      checkOutput({vecs[i].name, ".stall"}, pipe_stall, vecs[i].stall);
      checkOutput({vecs[i].name, ".memRd"}, mem_rd, vecs[i].mrd);
      checkOutput({vecs[i].name, ".memWr"}, mem_wr, vecs[i].mwr);
      checkOutput({vecs[i].name, ".memAddr"}, mem_addr, vecs[i].maddr);
      checkOutput({vecs[i].name, ".memWdata"}, mem_wdata, vecs[i].mwdata);
      if (vecs[i].chkPrdata)
        checkOutput({vecs[i].name, ".pipeRdata"}, pipe_rdata, shadow[vecs[i].paddr]);
      if (vecs[i].gnt && !vecs[i].ewe) expQ.push_back(shadow[vecs[i].eaddr]);
      if (vecs[i].mwr) shadow[vecs[i].maddr] = vecs[i].mwdata;
      nextCycle();
      driveIdle();
      @(negedge clk);
      checkOutput({vecs[i].name, ".rvalid"}, ext_rvalid, vecs[i].gnt && !vecs[i].ewe);
      nextCycle();
    end

    // Back-to-back external write then read of the same address.
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0050, 16'hC3C3);
    @(negedge clk);
    checkOutput("b2b.wrGnt", ext_gnt, 1'b1);
    checkOutput("b2b.memWr", mem_wr, 1'b1);
    shadow[16'h0050] = 16'hC3C3;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0050, 16'h0);
    @(negedge clk);
    checkOutput("b2b.rdGnt", ext_gnt, 1'b1);
    checkOutput("b2b.memRd", mem_rd, 1'b1);
    expQ.push_back(shadow[16'h0050]);
    nextCycle();
    driveIdle();
    @(negedge clk);
    checkOutput("b2b.rvalid", ext_rvalid, 1'b1);
    nextCycle();

`ifdef DMEM_ARB_STARVE_EN
    // Forced grant on the ninth refused cycle, then again with req held.
    starveRun("starve1", SM + 1, SM + 1, 16'h0020, 16'h1234, 16'h0000);
    starveRun("starve2", SM + 1, SM + 1, 16'h0021, 16'h5678, 16'h0100);
    driveIdle();
    nextCycle();

    // Request dropped in the FORCE cycle: no grant, no stall, back to PIPE.
    for (int k = 1; k <= SM; k++) begin
      applyStimulus(1'b0, 1'b1, 16'h0062, 16'(k), 1'b1, 1'b1, 16'h0022, 16'hDEAD);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 16'h0062, 16'h0009, 1'b0, 1'b1, 16'h0022, 16'hDEAD);
    @(negedge clk);
    checkOutput("dropAtMax.gnt", ext_gnt, 1'b0);
    checkOutput("dropAtMax.stall", pipe_stall, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 16'h0062, 16'h000A, 1'b1, 1'b1, 16'h0022, 16'hDEAD);
    @(negedge clk);
    checkOutput("dropAtMax.after", ext_gnt, 1'b0);
    nextCycle();
    driveIdle();
    nextCycle();

    // Reset during a pending FORCE abandons it.
    for (int k = 1; k <= SM; k++) begin
      applyStimulus(1'b0, 1'b1, 16'h0063, 16'(k), 1'b1, 1'b1, 16'h0023, 16'hBEAD);
      nextCycle();
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("forceRst.gnt", ext_gnt, 1'b0);
    checkOutput("forceRst.stall", pipe_stall, 1'b0);
    checkOutput("forceRst.memWr", mem_wr, 1'b0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("forceRst.after", ext_gnt, 1'b0);
    nextCycle();
    driveIdle();
    nextCycle();
`else
    // Strict priority: no grant and no stall until the pipeline goes idle.
    starveRun("starveOff", SM + 4, 0, 16'h0020, 16'h1234, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0060, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234);
    @(negedge clk);
    checkOutput("starveOff.idleGnt", ext_gnt, 1'b1);
    checkOutput("starveOff.idleStall", pipe_stall, 1'b0);
    checkOutput("starveOff.idleMemWr", mem_wr, 1'b1);
    shadow[16'h0020] = 16'h1234;
    nextCycle();
    driveIdle();
    nextCycle();
`endif

    // Reset in the cycle after a read grant suppresses the read-valid pulse.
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    checkOutput("rstMidRead.gnt", ext_gnt, 1'b1);
    nextCycle();
    driveIdle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstMidRead.rvalidInRst", ext_rvalid, 1'b0);
    checkOutput("rstMidRead.memRd", mem_rd, 1'b0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstMidRead.rvalidAfter", ext_rvalid, 1'b0);
    nextCycle();

    // Memory contents after all the arbitration above.
    readBack(16'h0020);
`ifdef DMEM_ARB_STARVE_EN
    readBack(16'h0021);
`endif
    readBack(16'h0060);
    readBack(16'h0030);
    readBack(16'h0007);

    driveIdle();
    nextCycle();
    nextCycle();
    checkOutput("scoreboardDrained", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
